sysa_seq: RTL

Single-clock job sequencer for the 3x3 weight-stationary systolic array (`sysa`). Accepts a stream of 24-bit words over a valid/ready port: three weight rows, then three input rows. Drives the array's weight-load, enable and input buses, de-skews the three column outputs into a 9-entry result buffer, and streams the nine 16-bit results out over a second valid/ready port. It replaces ad-hoc clock-divided sequencing between the Wishbone front end and the array.

---
 rtl/sysa_pkg.sv | 31 +++
 rtl/sysa_seq_if.sv | 30 +++
 rtl/sysa_resbuf.sv | 39 +++
 rtl/sysa_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sysa_pkg.sv
// ============================================================================
// sysa_pkg: shared constants, state encoding and capture-index helper for the
// 3x3 systolic-array job sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sysa_pkg;

   localparam int N          = 3;
   localparam int NRES       = N * N;
   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 16;
   localparam int DRAIN_DEF  = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_LOAD_I = 3'd2,
      S_DRAIN  = 3'd3,
      S_OUT    = 3'd4
   } seq_state_t;

   // Column j (1-based) result for input row r lives at slot 3*(j-1)+r.
   function automatic logic [3:0] cap_idx(input int j, input int r);
      return 4'(N * (j - 1) + r);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sysa_seq_if.sv
// ============================================================================
// sysa_seq_if: word-input and result-output valid/ready ports of the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sysa_seq_if #(
   parameter int DATA_W = sysa_pkg::DATA_W_DEF,
   parameter int ACC_W  = sysa_pkg::ACC_W_DEF
);
   logic                in_valid;
   logic                in_ready;
   logic [3*DATA_W-1:0] in_data;
   logic                res_valid;
   logic                res_ready;
   logic [ACC_W-1:0]    res_data;
   logic [3:0]          res_idx;

   modport slave (
      input  in_valid, in_data, res_ready,
      output in_ready, res_valid, res_data, res_idx
   );

   modport master (
      output in_valid, in_data, res_ready,
      input  in_ready, res_valid, res_data, res_idx
   );
endinterface

`default_nettype wire

// File: rtl/sysa_resbuf.sv
// ============================================================================
// sysa_resbuf: 9-entry result register file, three indexed write ports,
// one read mux, synchronous clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sysa_resbuf
   import sysa_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic [N-1:0]             we,
   input  logic [N-1:0][3:0]        widx,
   input  logic [N-1:0][ACC_W-1:0]  wdata,
   input  logic [3:0]               ridx,
   output logic [ACC_W-1:0]         rdata
);

   logic [ACC_W-1:0] mem [NRES];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < NRES; i++) mem[i] <= '0;
      end else begin
         for (int p = 0; p < N; p++) begin
            if (we[p] && int'(widx[p]) < NRES) mem[widx[p]] <= wdata[p];
         end
      end
   end

   assign rdata = (int'(ridx) < NRES) ? mem[ridx] : '0;

endmodule

`default_nettype wire

// File: rtl/sysa_seq.sv
// ============================================================================
// sysa_seq: loads weights and inputs into the 3x3 systolic array, de-skews the
// column outputs into a result buffer and streams the nine results out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sysa_seq
   import sysa_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int DRAIN  = DRAIN_DEF
) (
   input  logic                clk,
   input  logic                rst,
   sysa_seq_if.slave           bus,
   output logic                sa_wload,
   output logic [1:0]          sa_wrow,
   output logic [N*DATA_W-1:0] sa_w,
   output logic                sa_en,
   output logic [N*DATA_W-1:0] sa_in,
   input  logic [ACC_W-1:0]    sa_out1,
   input  logic [ACC_W-1:0]    sa_out2,
   input  logic [ACC_W-1:0]    sa_out3,
   output logic                busy,
   output logic                done
);

   localparam int ECNT_W = $clog2(N + DRAIN + 1);
   localparam int DCNT_W = $clog2(DRAIN + 1);

   seq_state_t          state, next_state;
   logic [1:0]          wcnt, nxt_wcnt;
   logic [ECNT_W-1:0]   ecnt;
   logic [DCNT_W-1:0]   dcnt, nxt_dcnt;
   logic [3:0]          ridx, nxt_ridx;
   logic                nxt_wload, nxt_en, nxt_done;
   logic [1:0]          nxt_wrow;
   logic [N*DATA_W-1:0] nxt_w, nxt_in;
   logic                buf_clr, ecnt_clr;
   logic                in_fire, res_fire;

   logic [N-1:0]             cap_we;
   logic [N-1:0][3:0]        cap_widx;
   logic [N-1:0][ACC_W-1:0]  cap_wdata;
   logic [ACC_W-1:0]         rd_data;

   assign bus.in_ready  = (state == S_IDLE || state == S_LOAD_W || state == S_LOAD_I) && !rst;
   assign bus.res_valid = (state == S_OUT);
   assign bus.res_idx   = ridx;
   assign bus.res_data  = rd_data;
   assign busy          = (state != S_IDLE);

   assign in_fire  = bus.in_valid && bus.in_ready;
   assign res_fire = bus.res_valid && bus.res_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      nxt_wcnt   = wcnt;
      nxt_dcnt   = dcnt;
      nxt_ridx   = ridx;
      nxt_wload  = 1'b0;
      nxt_wrow   = sa_wrow;
      nxt_w      = sa_w;
      nxt_en     = 1'b0;
      nxt_in     = sa_in;
      nxt_done   = 1'b0;
      buf_clr    = 1'b0;
      ecnt_clr   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (in_fire) begin
               buf_clr    = 1'b1;
               nxt_wload  = 1'b1;
               nxt_wrow   = 2'd0;
               nxt_w      = bus.in_data;
               nxt_wcnt   = 2'd1;
               next_state = S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            if (in_fire) begin
               nxt_wload = 1'b1;
               nxt_wrow  = wcnt;
               nxt_w     = bus.in_data;
               nxt_wcnt  = wcnt + 2'd1;
               if (wcnt == 2'd2) begin
                  nxt_wcnt   = 2'd0;
                  ecnt_clr   = 1'b1;
                  next_state = S_LOAD_I;
               end
            end
         end
         S_LOAD_I: begin
            // wcnt is reused here to count accepted input rows.
            if (in_fire) begin
               nxt_en   = 1'b1;
               nxt_in   = bus.in_data;
               nxt_wcnt = wcnt + 2'd1;
               if (wcnt == 2'd2) begin
                  nxt_dcnt   = '0;
                  next_state = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // One extra cycle after the last drain enable lets its capture land.
            if (dcnt != DCNT_W'(DRAIN)) begin
               nxt_en   = 1'b1;
               nxt_in   = '0;
               nxt_dcnt = dcnt + 1'b1;
            end else begin
               next_state = S_OUT;
            end
         end
         S_OUT: begin
            if (res_fire) begin
               if (ridx == 4'(NRES - 1)) begin
                  nxt_ridx   = '0;
                  nxt_done   = 1'b1;
                  next_state = S_IDLE;
               end else begin
                  nxt_ridx = ridx + 4'd1;
               end
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt     <= '0;
         dcnt     <= '0;
         ridx     <= '0;
         ecnt     <= '0;
         sa_wload <= 1'b0;
         sa_wrow  <= '0;
         sa_w     <= '0;
         sa_en    <= 1'b0;
         sa_in    <= '0;
         done     <= 1'b0;
      end else begin
         wcnt     <= nxt_wcnt;
         dcnt     <= nxt_dcnt;
         ridx     <= nxt_ridx;
         sa_wload <= nxt_wload;
         sa_wrow  <= nxt_wrow;
         sa_w     <= nxt_w;
         sa_en    <= nxt_en;
         sa_in    <= nxt_in;
         done     <= nxt_done;
         if (ecnt_clr)   ecnt <= '0;
         else if (sa_en) ecnt <= ecnt + 1'b1;
      end
   end

   // Column j+1 carries row r = ecnt-j-2 during enabled cycle ecnt.
   always_comb begin
      for (int j = 0; j < N; j++) begin
         cap_we[j]   = 1'b0;
         cap_widx[j] = '0;
         if (sa_en && int'(ecnt) >= j + 2 && int'(ecnt) <= j + 4) begin
            cap_we[j]   = 1'b1;
            cap_widx[j] = cap_idx(j + 1, int'(ecnt) - j - 2);
         end
      end
   end

   assign cap_wdata[0] = sa_out1;
   assign cap_wdata[1] = sa_out2;
   assign cap_wdata[2] = sa_out3;

   sysa_resbuf #(.ACC_W(ACC_W)) u_resbuf (
      .clk   (clk),
      .rst   (rst),
      .clr   (buf_clr),
      .we    (cap_we),
      .widx  (cap_widx),
      .wdata (cap_wdata),
      .ridx  (ridx),
      .rdata (rd_data)
   );

endmodule

`default_nettype wire
